// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: FIPS-197 known-answer self-test over a shared AES engine, with BCD display of a result byte
module aes_kat_sequencer #(
    parameter int NUM_KS     = 3,
    parameter int TIMEOUT    = 64,
    parameter int BYTE_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_KS-1:0]     ks_mask,
    input  logic [BYTE_IDX_W-1:0] disp_sel,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_KS-1:0]     pass_vec,
    output logic                  all_pass,
    output logic [NUM_KS-1:0]     timeout_vec,
    output logic                  eng_start,
    output logic [1:0]            eng_ks,
    output logic                  eng_decrypt,
    output logic [127:0]          eng_din,
    input  logic [127:0]          eng_dout,
    input  logic                  eng_valid,
    output logic [127:0]          last_result,
    output logic [11:0]           bcd,
    output logic                  bcd_valid
);
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, SEL, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, NEXT, FIN} state_t;

    state_t            state, state_next;
    logic [1:0]        ks;
    logic [NUM_KS-1:0] mask;
    logic              enc_ok;
    logic [CW-1:0]     cnt;
    logic [127:0]      exp_ct;
    logic              last_ks, timed_out, enc_phase, dec_phase;

    assign exp_ct    = (ks == 2'd0) ? CT0 : (ks == 2'd1) ? CT1 : CT2;
    assign last_ks   = (ks == 2'(NUM_KS - 1));
    assign timed_out = (cnt == CW'(TIMEOUT - 1));
    assign enc_phase = (state == ENC_REQ) || (state == ENC_WAIT);
    assign dec_phase = (state == DEC_REQ) || (state == DEC_WAIT);

    // Engine request fields are decoded from state so they stay put for the whole request/wait span.
    assign eng_start   = (state == ENC_REQ) || (state == DEC_REQ);
    assign eng_decrypt = dec_phase;
    assign eng_ks      = (enc_phase || dec_phase) ? ks : 2'd0;
    assign eng_din     = enc_phase ? PT : dec_phase ? last_result : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = start ? SEL : IDLE;
            SEL:      state_next = mask[ks] ? ENC_REQ : NEXT;
            ENC_REQ:  state_next = ENC_WAIT;
            ENC_WAIT: state_next = eng_valid ? DEC_REQ : timed_out ? NEXT : ENC_WAIT;
            DEC_REQ:  state_next = DEC_WAIT;
            DEC_WAIT: state_next = (eng_valid || timed_out) ? NEXT : DEC_WAIT;
            NEXT:     state_next = last_ks ? FIN : SEL;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ks          <= 2'd0;
            mask        <= '0;
            enc_ok      <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            all_pass    <= 1'b0;
            pass_vec    <= '0;
            timeout_vec <= '0;
            last_result <= '0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: if (start) begin
                    mask        <= ks_mask;
                    pass_vec    <= '0;
                    timeout_vec <= '0;
                    busy        <= 1'b1;
                    ks          <= 2'd0;
                end
                ENC_REQ, DEC_REQ: cnt <= '0;
                ENC_WAIT: begin
                    if (eng_valid) begin
                        last_result <= eng_dout;
                        enc_ok      <= (eng_dout == exp_ct);
                    end else if (timed_out) timeout_vec[ks] <= 1'b1;
                    else cnt <= cnt + CW'(1);
                end
                DEC_WAIT: begin
                    if (eng_valid) begin
                        last_result  <= eng_dout;
                        pass_vec[ks] <= enc_ok && (eng_dout == PT);
                    end else if (timed_out) timeout_vec[ks] <= 1'b1;
                    else cnt <= cnt + CW'(1);
                end
                NEXT: if (!last_ks) ks <= ks + 2'd1;
                FIN: begin
                    busy     <= 1'b0;
                    all_pass <= (pass_vec == mask) && (|mask);
                end
                default: ;
            endcase
        end
    end

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    logic [7:0]  sel_byte, prev_byte, bin;
    logic [11:0] acc, acc_adj, shifted;
    logic [3:0]  bcnt;
    logic        conv;

    assign sel_byte = last_result[{disp_sel, 3'b000} +: 8];
    assign acc_adj  = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    assign shifted  = 12'({acc_adj, bin[7]});

    // Double-dabble: one load cycle, then eight adjust-and-shift cycles; any new byte restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_byte <= '0;
            bin       <= '0;
            acc       <= '0;
            bcnt      <= '0;
            conv      <= 1'b0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else if (sel_byte != prev_byte) begin
            prev_byte <= sel_byte;
            bin       <= sel_byte;
            acc       <= '0;
            bcnt      <= 4'd8;
            conv      <= 1'b1;
            bcd_valid <= 1'b0;
        end else if (conv) begin
            acc  <= shifted;
            bin  <= {bin[6:0], 1'b0};
            bcnt <= bcnt - 4'd1;
            if (bcnt == 4'd1) begin
                conv      <= 1'b0;
                bcd       <= shifted;
                bcd_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb_aes_kat_sequencer: randomized known-answer runs against a behavioural engine and result model
module tb_aes_kat_sequencer;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   ks_mask = '0;
    logic [3:0]   disp_sel = '0;
    logic         busy, done, all_pass, eng_start, eng_decrypt, bcd_valid;
    logic [2:0]   pass_vec, timeout_vec;
    logic [1:0]   eng_ks;
    logic [127:0] eng_din, last_result;
    logic [127:0] eng_dout = '0;
    logic         eng_valid = 1'b0;
    logic [11:0]  bcd;

    int checks = 0;
    int failures = 0;
    int lat = 11;
    bit flip [3];
    bit drop_enc [3];
    bit drop_dec [3];
    logic [130:0] req_log [$];
    logic [127:0] model_last = '0;

    aes_kat_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ks_mask(ks_mask), .disp_sel(disp_sel),
        .busy(busy), .done(done), .pass_vec(pass_vec), .all_pass(all_pass),
        .timeout_vec(timeout_vec), .eng_start(eng_start), .eng_ks(eng_ks),
        .eng_decrypt(eng_decrypt), .eng_din(eng_din), .eng_dout(eng_dout),
        .eng_valid(eng_valid), .last_result(last_result), .bcd(bcd), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ct_of(input logic [1:0] k);
        return (k == 2'd0) ? CT0 : (k == 2'd1) ? CT1 : CT2;
    endfunction

    // Stand-in for AES decrypt: correct ciphertext yields plaintext, anything else yields garbage.
    function automatic logic [127:0] dec_of(input logic [1:0] k, input logic [127:0] c);
        return (c == ct_of(k)) ? PT : ~c;
    endfunction

    function automatic logic [11:0] bcd_of(input logic [7:0] b);
        int v;
        v = int'(b);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic clear_faults();
        for (int k = 0; k < 3; k++) begin
            flip[k] = 1'b0;
            drop_enc[k] = 1'b0;
            drop_dec[k] = 1'b0;
        end
    endtask

    // Engine: logs every request, answers after lat cycles unless told to stay silent.
    initial begin
        logic [1:0]   ek;
        logic         ed;
        logic [127:0] edin, eresp;
        forever begin
            @(negedge clk);
            eng_valid = 1'b0;
            if (eng_start === 1'b1 && !reset) begin
                ek = eng_ks;
                ed = eng_decrypt;
                edin = eng_din;
                req_log.push_back({ek, ed, edin});
                eresp = ed ? dec_of(ek, edin) : (ct_of(ek) ^ 128'(flip[ek]));
                if (!(ed ? drop_dec[ek] : drop_enc[ek])) begin
                    repeat (lat) @(negedge clk);
                    eng_valid = 1'b1;
                    eng_dout = eresp;
                end
            end
        end
    end

    task automatic run_kat(input string name, input logic [2:0] mask, input logic [3:0] sel, input bit extra);
        logic [2:0]   e_pass, e_to;
        logic         e_all;
        int           e_cyc, n, w, extra_done;
        logic [130:0] e_log [$];
        logic [127:0] ct, pt;
        logic [11:0]  e_bcd;
        e_pass = '0;
        e_to = '0;
        e_cyc = 2 * 3 + 2;
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                e_log.push_back({2'(k), 1'b0, PT});
                e_cyc += 1;
                if (drop_enc[k]) begin
                    e_to[k] = 1'b1;
                    e_cyc += 64;
                end else begin
                    ct = ct_of(2'(k)) ^ 128'(flip[k]);
                    model_last = ct;
                    e_cyc += lat + 1;
                    e_log.push_back({2'(k), 1'b1, ct});
                    if (drop_dec[k]) begin
                        e_to[k] = 1'b1;
                        e_cyc += 64;
                    end else begin
                        pt = dec_of(2'(k), ct);
                        model_last = pt;
                        e_cyc += lat;
                        e_pass[k] = !flip[k] && (pt == PT);
                    end
                end
            end
        end
        e_all = (mask != 3'b000) && (e_pass == mask);
        e_bcd = bcd_of(model_last[int'(sel) * 8 +: 8]);
        req_log.delete();
        disp_sel = sel;
        ks_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ks_mask = 3'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 1000) begin
            if (extra && n == 3) begin
                start = 1'b1;
                ks_mask = 3'b111;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        checks++;
        if (n !== e_cyc) begin failures++; $display("FAIL %s latency: got %0d cycles want %0d", name, n, e_cyc); end
        checks++;
        if (pass_vec !== e_pass) begin failures++; $display("FAIL %s pass_vec: got %b want %b", name, pass_vec, e_pass); end
        checks++;
        if (timeout_vec !== e_to) begin failures++; $display("FAIL %s timeout_vec: got %b want %b", name, timeout_vec, e_to); end
        checks++;
        if (all_pass !== e_all) begin failures++; $display("FAIL %s all_pass: got %b want %b", name, all_pass, e_all); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
        checks++;
        if (last_result !== model_last) begin failures++; $display("FAIL %s last_result: got %h want %h", name, last_result, model_last); end
        checks++;
        if (req_log.size() !== e_log.size()) begin
            failures++;
            $display("FAIL %s request_count: got %0d want %0d", name, req_log.size(), e_log.size());
        end else begin
            for (int i = 0; i < e_log.size(); i++) begin
                checks++;
                if (req_log[i] !== e_log[i]) begin failures++; $display("FAIL %s request_%0d: got %h want %h", name, i, req_log[i], e_log[i]); end
            end
        end
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin failures++; $display("FAIL %s extra_done: got %0d pulses want 0", name, extra_done); end
        w = 0;
        while (bcd_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bcd_valid !== 1'b1 || bcd !== e_bcd) begin failures++; $display("FAIL %s bcd: got %h valid %b want %h valid 1", name, bcd, bcd_valid, e_bcd); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, pass_vec, all_pass, timeout_vec, eng_start, eng_ks, eng_decrypt} !== 13'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h want 0", {busy, done, pass_vec, all_pass, timeout_vec, eng_start, eng_ks, eng_decrypt});
        end
        checks++;
        if (eng_din !== '0 || last_result !== '0) begin failures++; $display("FAIL reset_data: got %h/%h want 0", eng_din, last_result); end
        checks++;
        if ({bcd, bcd_valid} !== 13'd0) begin failures++; $display("FAIL reset_bcd: got %h want 0", {bcd, bcd_valid}); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_idle: got busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_single_128();
        clear_faults();
        lat = 11;
        run_kat("single_128", 3'b001, 4'd0, 1'b0);
        checks++;
        if (last_result !== PT) begin failures++; $display("FAIL single_128_plain: got %h want %h", last_result, PT); end
        checks++;
        if (bcd !== 12'h255) begin failures++; $display("FAIL single_128_bcd: got %h want 255", bcd); end
    endtask

    task automatic test_all_sizes();
        clear_faults();
        lat = 11;
        run_kat("all_sizes", 3'b111, 4'($urandom), 1'b0);
        checks++;
        if (pass_vec !== 3'b111 || timeout_vec !== 3'b000) begin failures++; $display("FAIL all_sizes_vec: got %b/%b want 111/000", pass_vec, timeout_vec); end
    endtask

    task automatic test_bad_192();
        bit dec_seen;
        clear_faults();
        flip[1] = 1'b1;
        lat = 11;
        run_kat("bad_192", 3'b111, 4'($urandom), 1'b0);
        dec_seen = 1'b0;
        foreach (req_log[i]) if (req_log[i][130:128] == 3'b011) dec_seen = 1'b1;
        checks++;
        if (pass_vec !== 3'b101 || all_pass !== 1'b0 || !dec_seen) begin
            failures++;
            $display("FAIL bad_192: got pass %b all %b dec_seen %b want 101 0 1", pass_vec, all_pass, dec_seen);
        end
    endtask

    task automatic test_timeout_256();
        clear_faults();
        drop_enc[2] = 1'b1;
        lat = 11;
        run_kat("timeout_256", 3'b111, 4'($urandom), 1'b0);
        checks++;
        if (timeout_vec !== 3'b100 || pass_vec !== 3'b011) begin failures++; $display("FAIL timeout_256: got to %b pass %b want 100 011", timeout_vec, pass_vec); end
    endtask

    task automatic test_zero_mask();
        clear_faults();
        run_kat("zero_mask", 3'b000, 4'($urandom), 1'b1);
        checks++;
        if ({pass_vec, timeout_vec, all_pass, eng_start} !== 8'd0) begin failures++; $display("FAIL zero_mask_outs: got %h want 0", {pass_vec, timeout_vec, all_pass, eng_start}); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        clear_faults();
        lat = 11;
        ks_mask = 3'b001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (eng_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || eng_din !== PT) begin failures++; $display("FAIL mid_run_pre: got busy %b din %h want 1 %h", busy, eng_din, PT); end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || eng_din !== '0 || last_result !== '0) begin
            failures++;
            $display("FAIL mid_run_async: got busy %b start %b din %h last %h want all 0", busy, eng_start, eng_din, last_result);
        end
        @(negedge clk);
        reset = 1'b0;
        model_last = '0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || last_result !== '0) begin failures++; $display("FAIL stray_valid: got busy %b last %h want 0 0", busy, last_result); end
    endtask

    task automatic test_encrypt_only();
        clear_faults();
        drop_dec[0] = 1'b1;
        lat = 11;
        run_kat("encrypt_only", 3'b001, 4'd0, 1'b0);
        checks++;
        if (last_result !== CT0 || bcd !== 12'h090) begin failures++; $display("FAIL encrypt_only: got %h bcd %h want %h bcd 090", last_result, bcd, CT0); end
    endtask

    task automatic test_bcd_latency();
        int first_valid;
        bit held;
        disp_sel = 4'd1;
        first_valid = 0;
        held = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bcd_valid === 1'b1 && first_valid == 0) first_valid = i;
            if (i < 9 && bcd !== 12'h090) held = 1'b0;
        end
        checks++;
        if (first_valid !== 9) begin failures++; $display("FAIL bcd_latency: got %0d cycles want 9", first_valid); end
        checks++;
        if (!held) begin failures++; $display("FAIL bcd_hold: got changing bcd want 090 held"); end
        checks++;
        if (bcd !== bcd_of(CT0[15:8])) begin failures++; $display("FAIL bcd_byte1: got %h want %h", bcd, bcd_of(CT0[15:8])); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_faults();
            lat = $urandom_range(1, 20);
            for (int k = 0; k < 3; k++) begin
                flip[k] = ($urandom_range(0, 3) == 0);
                drop_enc[k] = ($urandom_range(0, 5) == 0);
                drop_dec[k] = ($urandom_range(0, 5) == 0);
            end
            run_kat("random", 3'($urandom_range(1, 7)), 4'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_single_128();
        test_all_sizes();
        test_bad_192();
        test_timeout_256();
        test_zero_mask();
        test_reset_mid_run();
        test_encrypt_only();
        test_bcd_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_kat_sequencer.md
Name: aes_kat_sequencer

Overview:
- Known-answer self-test sequencer for the AES datapath.
- Drives a shared external encrypt/decrypt engine through a start/valid handshake and runs the FIPS-197 App. C vectors for each enabled key size: encrypt, compare, decrypt the result, compare.
- Records per-key-size pass/fail and tracks timeouts.
- Converts a selected result byte to 3-digit BCD with a sequential shift-add converter for the board display.

Parameters:
- NUM_KS, 3, number of key sizes sequenced (index 0=128, 1=192, 2=256).
- TIMEOUT, 64, max cycles from eng_start to eng_valid before the step fails.
- BYTE_IDX_W, 4, width of the display byte selector (16 bytes per block).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- ks_mask  in  NUM_KS  key sizes to test; sampled at accepted start.
- disp_sel  in  BYTE_IDX_W  byte of last_result shown on the display; byte 0 = bits [7:0].
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at run end.
- pass_vec  out  NUM_KS  per key size: 1 = both encrypt and decrypt matched.
- all_pass  out  1  pass_vec equals the sampled mask, and the mask is non-zero.
- timeout_vec  out  NUM_KS  per key size: 1 = a step timed out.
- eng_start  out  1  one-cycle request to the engine.
- eng_ks  out  2  key-size select to the engine.
- eng_decrypt  out  1  0 = encrypt, 1 = decrypt.
- eng_din  out  128  block to the engine.
- eng_dout  in  128  engine result.
- eng_valid  in  1  one-cycle result strobe.
- last_result  out  128  last eng_dout captured.
- bcd  out  12  BCD of the selected byte; [11:8] hundreds, [7:4] tens, [3:0] units.
- bcd_valid  out  1  bcd is stable for the current selection.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; BCD converter idle.
- Vectors:
  - Plaintext 00112233445566778899aabbccddeeff.
  - Expected ciphertext, 128: 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expected ciphertext, 192: dda97ca4864cdfe06eaf70a0ec0d7191.
  - Expected ciphertext, 256: 8ea2b7ca516745bfeafc49904b496089.
- FSM states: IDLE, SEL, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, NEXT, FIN.
  - IDLE: on start, latch ks_mask, clear pass_vec and timeout_vec, set busy, set ks=0, go to SEL.
  - SEL: if mask[ks]=1, go to ENC_REQ. Otherwise go to NEXT.
  - ENC_REQ: assert eng_start for one cycle with eng_decrypt=0, eng_din=plaintext, eng_ks=ks. Go to ENC_WAIT.
  - ENC_WAIT: count cycles.
    - On eng_valid: capture eng_dout into last_result and set enc_ok = (eng_dout == expected[ks]); go to DEC_REQ.
    - On count reaching TIMEOUT: set timeout_vec[ks]; go to NEXT.
  - DEC_REQ: eng_decrypt=1, eng_din=last_result. The decrypt always uses the engine's output, even when enc_ok=0.
  - DEC_WAIT: on eng_valid, capture eng_dout and set pass_vec[ks] = enc_ok & (eng_dout == plaintext). Timeout handling as in ENC_WAIT.
  - NEXT: if ks==NUM_KS-1, go to FIN. Otherwise ks+1 and go to SEL.
  - FIN: done=1 for one cycle, busy=0, all_pass updated, go to IDLE.
- eng_ks, eng_decrypt and eng_din are held stable from REQ until valid or timeout.
- eng_valid outside the WAIT states is ignored.
- Timeout counter restarts at each REQ.
- A pulse on start while busy is ignored.
- ks_mask=0: the run still walks SEL/NEXT and ends with done; pass_vec=0, all_pass=0. Latency is 2*NUM_KS+2 cycles from start to done.
- Reset mid-run: async return to IDLE; eng_start drops immediately; results cleared.
- BCD conversion:
  - Restarts whenever the selected byte changes (disp_sel or last_result changes).
  - bcd_valid=0 during conversion; 8 shift cycles plus 1 load cycle.
  - Add-3 is applied to any digit ≥5 before each shift.
  - bcd holds its previous value until the conversion completes.

Test Plan:
- Ideal engine (latency 11, returns correct AES), ks_mask=3'b001, start -> done; pass_vec=001, all_pass=1. With disp_sel=0: last_result = plaintext, bcd=0x255.
- Same engine, ks_mask=3'b111 -> three encrypt/decrypt pairs in order 128, 192, 256; pass_vec=111; timeout_vec=000.
- Engine flips bit 0 of the 192 ciphertext -> pass_vec=101, all_pass=0, and decrypt for 192 is still issued.
- Engine never asserts valid for 256 -> eng_start seen, timeout after 64 cycles; timeout_vec=100, pass_vec=011, done pulses.
- ks_mask=0 -> done 8 cycles after start; all outputs 0. A second start during busy in another run is ignored.
- Reset asserted in ENC_WAIT -> busy=0 and eng_start=0 without waiting for a clock edge. After encrypt-only capture of 69c4..c55a, disp_sel=0 -> bcd=0x090 within 9 cycles.
